led_pattern_sequencer: RTL and testbench

- Controller that owns the board's programmable tick divider and LED output.
- Software-side logic loads a blink pattern, step period and repeat count over a valid/ready config port, then starts and stops playback.
- Replaces a fixed free-running divider with a sequenced, reconfigurable LED driver. Intended as the top-level status-LED engine on the iCE40 test bitstream.

---
 rtl/led_seq_pkg.sv | 23 ++
 rtl/tick_gen.sv | 33 +++
 rtl/led_pattern_sequencer.sv | 149 ++++++++++++++
 tb/tb_led_pattern_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and constants for the LED pattern sequencer and its helpers.
package led_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    // Bit-index width for the default 16-bit pattern.
    localparam int PATTERN_WIDTH_DEFAULT = 16;
    localparam int IDX_WIDTH_DEFAULT     = $clog2(PATTERN_WIDTH_DEFAULT);

    // Configuration values loaded by reset.
    localparam int PATTERN_RESET = 0;
    localparam int REPEAT_RESET  = 1;

    // Index width for an arbitrary pattern length, never narrower than one bit.
    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Programmable step divider: pulses tick once every max(div, 1) enabled cycles.
module tick_gen #(
    parameter int pDivWidth = 24
) (
    input  logic                 iwClk,
    input  logic                 iwnRst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic [pDivWidth-1:0] div,
    output logic                 tick
);

    localparam logic [pDivWidth-1:0] One = {{(pDivWidth-1){1'b0}}, 1'b1};

    logic [pDivWidth-1:0] count;
    logic [pDivWidth-1:0] last;

    // A zero period behaves as one, so the terminal value never underflows.
    assign last = (div == '0) ? '0 : (div - One);
    assign tick = enable && (count == last);

    // Count 0..last while enabled, wrapping on the terminal count.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : (count + One);
        end
    end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Status-LED engine: plays a configured bit pattern LSB first, one bit per
// step period, for a programmable number of passes (0 = forever).
//
// state | meaning
// IDLE  | waiting; config port ready, start launches playback
// RUN   | pattern playing, one bit per step tick
// DONE  | single-cycle completion marker, then back to IDLE
module led_pattern_sequencer
    import led_seq_pkg::*;
#(
    parameter int pPatternWidth = 16,
    parameter int pDivWidth     = 24,
    parameter int pDefaultDiv   = 4000000,
    parameter int pRepeatWidth  = 8
) (
    input  logic                     iwClk,
    input  logic                     iwnRst,
    input  logic                     iwCfgValid,
    output logic                     owCfgReady,
    input  logic [pPatternWidth-1:0] iwCfgPattern,
    input  logic [pDivWidth-1:0]     iwCfgDiv,
    input  logic [pRepeatWidth-1:0]  iwCfgRepeat,
    input  logic                     iwStart,
    input  logic                     iwStop,
    output logic                     orLed,
    output logic                     orBusy,
    output logic                     orDone,
    output logic                     orStepTick
);

    localparam int                      IdxW    = idx_width(pPatternWidth);
    localparam logic [IdxW-1:0]         IdxLast = IdxW'(pPatternWidth - 1);
    localparam logic [IdxW-1:0]         IdxOne  = IdxW'(1);
    localparam logic [pRepeatWidth-1:0] RepOne  = pRepeatWidth'(1);

    seq_state_t              state;
    logic [pPatternWidth-1:0] cfg_pattern;
    logic [pDivWidth-1:0]     cfg_div;
    logic [pRepeatWidth-1:0]  cfg_repeat;
    logic [IdxW-1:0]          idx;
    logic [IdxW-1:0]          idx_next;
    logic [pRepeatWidth-1:0]  rep_cnt;

    logic                     cfg_accept;
    logic [pPatternWidth-1:0] start_pattern;
    logic [pRepeatWidth-1:0]  start_repeat;
    logic                     running;
    logic                     tick_clear;
    logic                     step_tick;

    assign owCfgReady = (state == IDLE);
    assign cfg_accept = iwCfgValid && owCfgReady;

    // A word arriving with start is used by the run it launches.
    assign start_pattern = cfg_accept ? iwCfgPattern : cfg_pattern;
    assign start_repeat  = cfg_accept ? iwCfgRepeat  : cfg_repeat;

    assign running    = (state == RUN);
    assign tick_clear = !running || iwStop;
    assign idx_next   = idx + IdxOne;
    assign orStepTick = step_tick;

    tick_gen #(
        .pDivWidth (pDivWidth)
    ) u_tick_gen (
        .iwClk  (iwClk),
        .iwnRst (iwnRst),
        .enable (running),
        .clear  (tick_clear),
        .div    (cfg_div),
        .tick   (step_tick)
    );

    // Config registers; only writable while the handshake is open in IDLE.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            cfg_pattern <= pPatternWidth'(PATTERN_RESET);
            cfg_div     <= pDivWidth'(pDefaultDiv);
            cfg_repeat  <= pRepeatWidth'(REPEAT_RESET);
        end else if (cfg_accept) begin
            cfg_pattern <= iwCfgPattern;
            cfg_div     <= iwCfgDiv;
            cfg_repeat  <= iwCfgRepeat;
        end
    end

    // Playback FSM with bit index, pass counter and registered LED/status outputs.
    always_ff @(posedge iwClk or negedge iwnRst) begin
        if (!iwnRst) begin
            state   <= IDLE;
            idx     <= '0;
            rep_cnt <= '0;
            orLed   <= 1'b0;
            orBusy  <= 1'b0;
            orDone  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    orDone <= 1'b0;
                    if (iwStart) begin
                        state   <= RUN;
                        idx     <= '0;
                        rep_cnt <= start_repeat;
                        orLed   <= start_pattern[0];
                        orBusy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (iwStop) begin
                        state  <= IDLE;
                        idx    <= '0;
                        orLed  <= 1'b0;
                        orBusy <= 1'b0;
                    end else if (step_tick) begin
                        if (idx != IdxLast) begin
                            idx   <= idx_next;
                            orLed <= cfg_pattern[idx_next];
                        end else begin
                            idx <= '0;
                            if (rep_cnt == '0) begin
                                orLed <= cfg_pattern[0];
                            end else if (rep_cnt > RepOne) begin
                                rep_cnt <= rep_cnt - RepOne;
                                orLed   <= cfg_pattern[0];
                            end else begin
                                state  <= DONE;
                                orLed  <= 1'b0;
                                orDone <= 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    orDone <= 1'b0;
                    orBusy <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    idx    <= '0;
                    orLed  <= 1'b0;
                    orBusy <= 1'b0;
                    orDone <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Directed bench for led_pattern_sequencer: handshake, timing, repeat, stop and reset.
module tb_led_pattern_sequencer;

    logic        clk;
    logic        rst_b;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [15:0] cfg_pattern;
    logic [23:0] cfg_div;
    logic [7:0]  cfg_repeat;
    logic        start;
    logic        stop;
    logic        led;
    logic        busy;
    logic        done;
    logic        step_tick;

    int n_cmp = 0;
    int n_bad = 0;

    logic led_log   [0:199];
    logic done_log  [0:199];
    logic tick_log  [0:199];
    logic ready_log [0:199];
    logic busy_log  [0:199];

    led_pattern_sequencer #(
        .pPatternWidth (16),
        .pDivWidth     (24),
        .pDefaultDiv   (4000000),
        .pRepeatWidth  (8)
    ) dut (
        .iwClk        (clk),
        .iwnRst       (rst_b),
        .iwCfgValid   (cfg_valid),
        .owCfgReady   (cfg_ready),
        .iwCfgPattern (cfg_pattern),
        .iwCfgDiv     (cfg_div),
        .iwCfgRepeat  (cfg_repeat),
        .iwStart      (start),
        .iwStop       (stop),
        .orLed        (led),
        .orBusy       (busy),
        .orDone       (done),
        .orStepTick   (step_tick)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    // Samples cycles first..last after successive edges; start is a one-edge pulse.
    task automatic observe(input int first, input int last);
        for (int c = first; c <= last; c++) begin
            @(posedge clk);
            #1;
            start        = 1'b0;
            led_log[c]   = led;
            done_log[c]  = done;
            tick_log[c]  = step_tick;
            ready_log[c] = cfg_ready;
            busy_log[c]  = busy;
        end
    endtask

    task automatic load_cfg(input logic [15:0] p, input logic [23:0] d, input logic [7:0] r);
        cfg_valid   = 1'b1;
        cfg_pattern = p;
        cfg_div     = d;
        cfg_repeat  = r;
        cycle();
        cfg_valid   = 1'b0;
    endtask

    function automatic int count_set(input logic arr [0:199], input int first, input int last);
        int n = 0;
        for (int c = first; c <= last; c++) if (arr[c] === 1'b1) n++;
        return n;
    endfunction

    function automatic int first_set(input logic arr [0:199], input int first, input int last);
        for (int c = first; c <= last; c++) if (arr[c] === 1'b1) return c;
        return -1;
    endfunction

    // Expected LED in cycle c is bit ((c-1)/deff) mod 16 of the pattern.
    function automatic int led_errs(input logic [15:0] pat, input int deff, input int first, input int last);
        int n = 0;
        for (int c = first; c <= last; c++)
            if (led_log[c] !== pat[((c - 1) / deff) % 16]) n++;
        return n;
    endfunction

    initial begin
        rst_b       = 1'b0;
        cfg_valid   = 1'b0;
        cfg_pattern = '0;
        cfg_div     = '0;
        cfg_repeat  = '0;
        start       = 1'b0;
        stop        = 1'b0;
        #23;
        check_eq("rst_led",   led,       0);
        check_eq("rst_busy",  busy,      0);
        check_eq("rst_done",  done,      0);
        check_eq("rst_tick",  step_tick, 0);
        check_eq("rst_ready", cfg_ready, 1);
        rst_b = 1'b1;
        cycle();

        // Pattern A5A5, 4 cycles per bit, single pass.
        load_cfg(16'hA5A5, 24'd4, 8'd1);
        start = 1'b1;
        observe(1, 66);
        check_eq("t1_led_seq",    led_errs(16'hA5A5, 4, 1, 64), 0);
        check_eq("t1_busy_run",   count_set(busy_log, 1, 65), 65);
        check_eq("t1_ready_run",  count_set(ready_log, 1, 65), 0);
        check_eq("t1_ticks",      count_set(tick_log, 1, 66), 16);
        check_eq("t1_done_cnt",   count_set(done_log, 1, 66), 1);
        check_eq("t1_done_cyc",   first_set(done_log, 1, 66), 65);
        check_eq("t1_led_done",   led_log[65], 0);
        check_eq("t1_ready_back", ready_log[66], 1);
        check_eq("t1_busy_back",  busy_log[66], 0);

        // Zero period behaves as one: step every cycle, three passes.
        load_cfg(16'h0001, 24'd0, 8'd3);
        start = 1'b1;
        observe(1, 52);
        check_eq("t2_led_cnt",  count_set(led_log, 1, 52), 3);
        check_eq("t2_led_1",    led_log[1], 1);
        check_eq("t2_led_17",   led_log[17], 1);
        check_eq("t2_led_33",   led_log[33], 1);
        check_eq("t2_ticks",    count_set(tick_log, 1, 52), 48);
        check_eq("t2_done_cnt", count_set(done_log, 1, 52), 1);
        check_eq("t2_done_cyc", first_set(done_log, 1, 52), 49);

        // Infinite repeat, then stop on a tick cycle.
        load_cfg(16'h0003, 24'd2, 8'd0);
        start = 1'b1;
        observe(1, 100);
        check_eq("t3_led_seq",  led_errs(16'h0003, 2, 1, 100), 0);
        check_eq("t3_led_97",   led_log[97], 1);
        check_eq("t3_no_done",  count_set(done_log, 1, 100), 0);
        check_eq("t3_busy",     count_set(busy_log, 1, 100), 100);
        check_eq("t3_tick_100", tick_log[100], 1);
        check_eq("t3_led_100",  led_log[100], 1);
        stop = 1'b1;
        observe(101, 104);
        stop = 1'b0;
        check_eq("t3_stop_led",   led_log[101], 0);
        check_eq("t3_stop_ready", ready_log[101], 1);
        check_eq("t3_stop_busy",  busy_log[101], 0);
        check_eq("t3_stop_done",  count_set(done_log, 101, 104), 0);
        check_eq("t3_stop_tick",  count_set(tick_log, 101, 104), 0);

        // Config offered during RUN is held off until IDLE.
        load_cfg(16'h00FF, 24'd1, 8'd1);
        start = 1'b1;
        observe(1, 1);
        cfg_valid   = 1'b1;
        cfg_pattern = 16'hFF00;
        cfg_div     = 24'd3;
        cfg_repeat  = 8'd2;
        observe(2, 18);
        check_eq("t4_led_seq",    led_errs(16'h00FF, 1, 1, 16), 0);
        check_eq("t4_ready_run",  count_set(ready_log, 1, 17), 0);
        check_eq("t4_done_cyc",   first_set(done_log, 1, 18), 17);
        check_eq("t4_ready_idle", ready_log[18], 1);
        cycle();
        cfg_valid = 1'b0;
        start     = 1'b1;
        observe(1, 98);
        check_eq("t4_new_led",  led_errs(16'hFF00, 3, 1, 96), 0);
        check_eq("t4_new_l25",  led_log[25], 1);
        check_eq("t4_new_done", first_set(done_log, 1, 98), 97);
        check_eq("t4_new_dcnt", count_set(done_log, 1, 98), 1);

        // Config and start together: the new word drives the run.
        cfg_valid   = 1'b1;
        cfg_pattern = 16'hFFFF;
        cfg_div     = 24'd5;
        cfg_repeat  = 8'd1;
        start       = 1'b1;
        observe(1, 1);
        cfg_valid = 1'b0;
        observe(2, 6);
        check_eq("t5_led_first", led_log[1], 1);
        check_eq("t5_busy",      busy_log[1], 1);
        check_eq("t5_tick_cyc",  first_set(tick_log, 1, 6), 5);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_eq("t5_stop_ready", cfg_ready, 1);

        // Asynchronous reset during bit 7 of pass 2.
        load_cfg(16'h0080, 24'd4, 8'd3);
        start = 1'b1;
        observe(1, 94);
        check_eq("t6_led_94",  led_log[94], 1);
        check_eq("t6_busy_94", busy_log[94], 1);
        rst_b = 1'b0;
        #2;
        check_eq("t6_rst_led",   led, 0);
        check_eq("t6_rst_busy",  busy, 0);
        check_eq("t6_rst_done",  done, 0);
        check_eq("t6_rst_tick",  step_tick, 0);
        check_eq("t6_rst_ready", cfg_ready, 1);
        #1;
        rst_b = 1'b1;
        start = 1'b1;
        observe(1, 150);
        check_eq("t6_def_busy",  busy_log[1], 1);
        check_eq("t6_def_ticks", count_set(tick_log, 1, 150), 0);
        check_eq("t6_def_led",   count_set(led_log, 1, 150), 0);
        check_eq("t6_def_done",  count_set(done_log, 1, 150), 0);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        check_eq("t6_stop_busy", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
